dump_sequencer: RTL and testbench
=================================

Name: dump_sequencer

Overview:
- Scheduler for the tracking-engine channel-state dump path.
- Arbitrates round-robin among per-channel dump requests and selects the winning physical channel on the state mux (ch_sel).
- Steps the 5-bit state address through the fixed dump list and captures each registered state word (state_d4wt, one cycle later) into the state buffer RAM at {channel, state_addr}.
- Sits between channel correlators (requesters), the per-channel state-select mux, and the CPU-visible state buffer.

Parameters:
CH_NUM, 4, number of physical channels / requesters
CH_W, 2, channel index width (clog2(CH_NUM), minimum 1)
COR_NUM, 8, accumulator words per channel, addresses 16..16+COR_NUM-1 (legal 1..16)

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock, reset is synchronous and active-high
enable  input  1  sequencer enable; sampled only in IDLE
dump_req  input  CH_NUM  per-channel dump request, level, held until acked
dump_ack  output  CH_NUM  one-hot, one-cycle grant acknowledge
ch_sel  output  CH_W  channel selected on state mux
state_addr  output  5  state word address to dump mux
state_d4wt  input  32  registered mux data, valid 1 cycle after state_addr
buf_we  output  1  state buffer write enable
buf_addr  output  CH_W+5  {channel, word address}
buf_wdata  output  32  equals state_d4wt
busy  output  1  high from grant through the final write
dump_done  output  1  one-cycle pulse coincident with the last write
done_ch  output  CH_W  channel of the completed dump, valid with dump_done

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; dump_ack=0, ch_sel=0, state_addr=0, buf_we=0, buf_addr=0, busy=0, dump_done=0, done_ch=0; RR pointer=0 (ch0 highest priority). Any in-progress dump is aborted; no further writes occur.
- Dump list, in order: 6,7,8,9,10,11,12,13,15, then 16..16+COR_NUM-1. Addresses 0-5 and 14 are never issued. Sequence length L=9+COR_NUM.
- FSM states: IDLE, SCAN, FLUSH.
- IDLE:
  - state_addr=0, buf_we=0.
  - If enable and |dump_req: winner = first set request at or after the RR pointer (wrapping). cur_ch<=winner; go to SCAN. This is the grant cycle G.
- SCAN, cycles G+1..G+L:
  - state_addr steps through the list, one entry per cycle; ch_sel=cur_ch; busy=1.
  - dump_ack[cur_ch]=1 in cycle G+1 only.
  - After the last entry, go to FLUSH.
- Write pipeline:
  - addr_d1 and valid_d1 are registered copies of state_addr and (state==SCAN).
  - buf_we=valid_d1; buf_addr={cur_ch, addr_d1}; buf_wdata=state_d4wt. Writes therefore occur in cycles G+2..G+L+1.
- FLUSH, cycle G+L+1:
  - Final write; dump_done=1; done_ch=cur_ch; busy=1.
  - RR pointer <= (cur_ch+1) mod CH_NUM; go to IDLE.
  - Next grant earliest at G+L+2.
- Defaults (CH_NUM=4, COR_NUM=8): L=17; writes G+2..G+18; dump_done at G+18.
- enable deasserted mid-dump: the current channel completes; no new grant is made while enable=0.
- dump_req[cur_ch] dropped mid-dump: ignored; the sequence completes.
- Request of the just-serviced channel reasserted: that channel loses to any other pending request (RR).
- Single requester repeating: served back-to-back, one IDLE cycle between dumps.
- ch_sel holds its last value in IDLE.
- RR pointer wraps: CH_NUM-1 -> 0.

Decomposition:
- Shared package dump_pkg:
  - constants for the state word addresses (ST_PRN_STATE=6 ... ST_DECODE=13, ST_PRN2=15, ST_ACC_BASE=16) and NUM_FIXED_WORDS=9;
  - FSM state enum {IDLE, SCAN, FLUSH}.
- Sub-module rr_arbiter (CH_NUM): request vector and pointer in; one-hot grant and encoded index out; purely combinational. Pointer update stays in dump_sequencer.

Test Plan:
- Single request: dump_req=4'b0100 at G, enable=1 ->
  - dump_ack=4'b0100 at G+1;
  - state_addr 6,7,...,13,15,16..23;
  - 17 writes at buf_addr 0x46..0x4D, 0x4F, 0x50..0x57, with data equal to a mux model returning {addr,ch} patterns;
  - dump_done with done_ch=2 at G+18.
- All four requesting continuously from reset -> grant order 0,1,2,3,0; grants 19 cycles apart; no write to addresses 0-5 or 14.
- Requests 4'b1001 after servicing ch0 -> next grant ch3, then ch0.
- enable=0 asserted at G+5 during a dump of ch1 -> all 17 writes complete, dump_done asserted; no grant while enable=0 even with dump_req=4'b1111.
- rst=1 at G+8 -> next cycle buf_we=0, busy=0, state_addr=0, RR pointer=0; after release with req=4'b1010, ch1 granted first.
- COR_NUM=1, CH_NUM=2 build -> L=10; last address 16; dump_done at G+11; buf_addr width 6.

Source files
------------

// File: rtl/dump_pkg.sv
// Shared constants and types for the channel-state dump path:
// state word addresses, dump-list helpers and the sequencer FSM states.
package dump_pkg;

    localparam logic [4:0] ST_PRN_STATE = 5'd6;
    localparam logic [4:0] ST_CARR_NCO  = 5'd7;
    localparam logic [4:0] ST_CODE_NCO  = 5'd8;
    localparam logic [4:0] ST_CARR_CNT  = 5'd9;
    localparam logic [4:0] ST_CODE_CNT  = 5'd10;
    localparam logic [4:0] ST_BIT_SYNC  = 5'd11;
    localparam logic [4:0] ST_FRAME     = 5'd12;
    localparam logic [4:0] ST_DECODE    = 5'd13;
    localparam logic [4:0] ST_PRN2      = 5'd15;
    localparam logic [4:0] ST_ACC_BASE  = 5'd16;

    localparam int NUM_FIXED_WORDS = 9;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FLUSH
    } fsm_e;

    // Word 14 is not part of the dump list, so the walk hops over it.
    function automatic logic [4:0] next_addr(input logic [4:0] a);
        return (a == ST_DECODE) ? ST_PRN2 : a + 5'd1;
    endfunction

endpackage

// File: rtl/dump_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first request at or after the pointer,
// wrapping; returns one-hot grant and encoded index.
module rr_arbiter #(
    parameter int CH_NUM = 4,
    parameter int CH_W   = 2
) (
    input  logic [CH_NUM-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [CH_NUM-1:0] gnt_o,
    output logic [CH_W-1:0]   idx_o
);

    int              sum;
    logic [CH_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        sum   = 0;
        cand  = '0;
        // Walk from farthest to nearest so the nearest hit wins.
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            sum = int'(ptr_i) + i;
            if (sum >= CH_NUM) begin
                sum = sum - CH_NUM;
            end
            cand = CH_W'(sum);
            if (req_i[cand]) begin
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/dump_sequencer.sv
// Channel-state dump scheduler: grants one channel round-robin, walks the
// dump list on the state mux and writes each returned word to the buffer.
module dump_sequencer
    import dump_pkg::*;
#(
    parameter int CH_NUM  = 4,
    parameter int CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
    parameter int COR_NUM = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [CH_NUM-1:0] dump_req,
    output logic [CH_NUM-1:0] dump_ack,
    output logic [CH_W-1:0]   ch_sel,
    output logic [4:0]        state_addr,
    input  logic [31:0]       state_d4wt,
    output logic              buf_we,
    output logic [CH_W+4:0]   buf_addr,
    output logic [31:0]       buf_wdata,
    output logic              busy,
    output logic              dump_done,
    output logic [CH_W-1:0]   done_ch
);

    localparam logic [4:0] LAST_ADDR = 5'(ST_ACC_BASE + COR_NUM - 1);

    fsm_e              state_q;
    logic [CH_W-1:0]   cur_ch_q;
    logic [CH_W-1:0]   ptr_q;
    logic [CH_W-1:0]   done_ch_q;
    logic [CH_NUM-1:0] ack_q;
    logic [4:0]        addr_q;
    logic [4:0]        addr_d;
    logic [4:0]        addr_d1_q;
    logic              valid_d1_q;
    logic              busy_q;
    logic              done_q;
    logic [CH_NUM-1:0] win_oh;
    logic [CH_W-1:0]   win_idx;

    rr_arbiter #(
        .CH_NUM (CH_NUM),
        .CH_W   (CH_W)
    ) u_arb (
        .req_i  (dump_req),
        .ptr_i  (ptr_q),
        .gnt_o  (win_oh),
        .idx_o  (win_idx)
    );

    assign addr_d = next_addr(addr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_ch_q   <= '0;
            ptr_q      <= '0;
            done_ch_q  <= '0;
            ack_q      <= '0;
            addr_q     <= '0;
            addr_d1_q  <= '0;
            valid_d1_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ack_q      <= '0;
            done_q     <= 1'b0;
            addr_d1_q  <= addr_q;
            valid_d1_q <= (state_q == SCAN);
            unique case (state_q)
                IDLE: begin
                    if (enable && (|dump_req)) begin
                        state_q  <= SCAN;
                        cur_ch_q <= win_idx;
                        ack_q    <= win_oh;
                        addr_q   <= ST_PRN_STATE;
                        busy_q   <= 1'b1;
                    end
                end
                SCAN: begin
                    if (addr_q == LAST_ADDR) begin
                        state_q   <= FLUSH;
                        addr_q    <= '0;
                        done_q    <= 1'b1;
                        done_ch_q <= cur_ch_q;
                    end else begin
                        addr_q <= addr_d;
                    end
                end
                FLUSH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ptr_q   <= (cur_ch_q == CH_W'(CH_NUM - 1)) ?
                               '0 : cur_ch_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dump_ack   = ack_q;
    assign ch_sel     = cur_ch_q;
    assign state_addr = addr_q;
    assign buf_we     = valid_d1_q;
    assign buf_addr   = {cur_ch_q, addr_d1_q};
    assign buf_wdata  = state_d4wt;
    assign busy       = busy_q;
    assign dump_done  = done_q;
    assign done_ch    = done_ch_q;

endmodule

// File: tb/tb_dump_sequencer.sv
// Bench for dump_sequencer: random mux contents and requests checked
// against a list/round-robin reference model.
module tb_dump_sequencer;

    localparam int L = 9 + 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  dump_req = 4'b0;
    logic [31:0] state_d4wt = '0;
    logic [3:0]  dump_ack;
    logic [1:0]  ch_sel;
    logic [4:0]  state_addr;
    logic        buf_we;
    logic [6:0]  buf_addr;
    logic [31:0] buf_wdata;
    logic        busy;
    logic        dump_done;
    logic [1:0]  done_ch;

    logic        en2 = 1'b0;
    logic [1:0]  req2 = 2'b0;
    logic [31:0] d4wt2 = '0;
    logic [1:0]  ack2;
    logic        ch_sel2;
    logic [4:0]  addr2;
    logic        we2;
    logic [5:0]  baddr2;
    logic [31:0] wdata2;
    logic        busy2;
    logic        done2;
    logic        done_ch2;

    logic [31:0] mem [4][32];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ref_ptr = 0;
    int bad_wr = 0;

    dump_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .dump_req   (dump_req),
        .dump_ack   (dump_ack),
        .ch_sel     (ch_sel),
        .state_addr (state_addr),
        .state_d4wt (state_d4wt),
        .buf_we     (buf_we),
        .buf_addr   (buf_addr),
        .buf_wdata  (buf_wdata),
        .busy       (busy),
        .dump_done  (dump_done),
        .done_ch    (done_ch)
    );

    dump_sequencer #(
        .CH_NUM  (2),
        .COR_NUM (1)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .enable     (en2),
        .dump_req   (req2),
        .dump_ack   (ack2),
        .ch_sel     (ch_sel2),
        .state_addr (addr2),
        .state_d4wt (d4wt2),
        .buf_we     (we2),
        .buf_addr   (baddr2),
        .buf_wdata  (wdata2),
        .busy       (busy2),
        .dump_done  (done2),
        .done_ch    (done_ch2)
    );

    always #5 clk = ~clk;

    // Registered state mux: data for the address presented last cycle.
    always @(posedge clk) begin
        state_d4wt <= mem[ch_sel][state_addr];
        d4wt2      <= mem[{1'b0, ch_sel2}][addr2];
    end

    always @(negedge clk) begin
        if (buf_we === 1'b1 &&
            (buf_addr[4:0] < 5'd6 || buf_addr[4:0] == 5'd14))
            bad_wr++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int list_addr(input int k);
        if (k < 8) return 6 + k;
        if (k == 8) return 15;
        return 16 + (k - 9);
    endfunction

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++)
            if (r[2'((p + i) % 4)]) return (p + i) % 4;
        return 0;
    endfunction

    // Waits for a grant, then checks every cycle of the dump.
    task automatic do_dump(input int en_off, input int rst_at,
                           input bit drop, output int ack_cyc);
        int n;
        int ch;
        int a;
        n = 0;
        ack_cyc = -1;
        while (dump_ack === 4'b0 && n < 60) begin
            tick();
            n++;
        end
        chk("grant_wait", (n < 60), 1);
        if (n >= 60) return;
        ack_cyc = cyc;
        ch = rr_pick(dump_req, ref_ptr);
        for (int k = 0; k <= L; k++) begin
            chk("ack", dump_ack, (k == 0) ? (1 << ch) : 0);
            chk("ch_sel", ch_sel, ch);
            chk("busy", busy, 1);
            if (k < L) begin
                chk("addr", state_addr, list_addr(k));
                chk("done_early", dump_done, 0);
            end else begin
                chk("done", dump_done, 1);
                chk("done_ch", done_ch, ch);
            end
            if (k == 0) begin
                chk("we_first", buf_we, 0);
            end else begin
                a = list_addr(k - 1);
                chk("we", buf_we, 1);
                chk("waddr", buf_addr, ch * 32 + a);
                chk("wdata", buf_wdata, mem[2'(ch)][5'(a)]);
            end
            if (drop && k == 0) dump_req = 4'b0;
            if (k == en_off - 1) begin
                enable = 1'b0;
                dump_req = 4'b1111;
            end
            if (k == rst_at - 1) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk("rst_we", buf_we, 0);
                chk("rst_busy", busy, 0);
                chk("rst_addr", state_addr, 0);
                chk("rst_done", dump_done, 0);
                ref_ptr = 0;
                return;
            end
            tick();
        end
        chk("busy_end", busy, 0);
        chk("we_end", buf_we, 0);
        chk("done_end", dump_done, 0);
        ref_ptr = (ch + 1) % 4;
    endtask

    initial begin
        int c0;
        int c1;
        int n;
        int last;
        logic [3:0] r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 32; j++)
                mem[i][j] = $urandom;

        tick();
        tick();
        chk("rst_ack", dump_ack, 0);
        chk("rst_sel", ch_sel, 0);
        chk("rst_saddr", state_addr, 0);
        chk("rst_bwe", buf_we, 0);
        chk("rst_baddr", buf_addr, 0);
        chk("rst_bsy", busy, 0);
        chk("rst_dd", dump_done, 0);
        chk("rst_dch", done_ch, 0);
        rst = 1'b0;
        ref_ptr = 0;

        // Single requester, channel 2.
        enable = 1'b1;
        dump_req = 4'b0100;
        do_dump(0, 0, 0, c0);
        dump_req = 4'b0;
        tick();

        // All four from reset: 0,1,2,3,0 with fixed spacing.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ref_ptr = 0;
        dump_req = 4'b1111;
        do_dump(0, 0, 0, c0);
        for (int i = 0; i < 4; i++) begin
            do_dump(0, 0, 0, c1);
            chk("spacing", c1 - c0, 19);
            c0 = c1;
        end

        // After ch0, 1001 -> ch3 then ch0.
        dump_req = 4'b1001;
        do_dump(0, 0, 0, c0);
        dump_req = 4'b1001;
        do_dump(0, 0, 0, c0);
        dump_req = 4'b0;
        tick();

        // Enable dropped mid-dump of ch1.
        dump_req = 4'b0010;
        do_dump(5, 0, 0, c0);
        for (int i = 0; i < 6; i++) begin
            chk("no_grant_dis", dump_ack, 0);
            chk("idle_dis", busy, 0);
            tick();
        end
        enable = 1'b1;
        do_dump(0, 0, 0, c0);

        // Reset mid-dump, then 1010 must pick ch1.
        do_dump(0, 8, 0, c0);
        dump_req = 4'b1010;
        do_dump(0, 0, 0, c0);
        dump_req = 4'b0;

        // Random requests, random drops and gaps.
        for (int it = 0; it < 10; it++) begin
            r = 4'($urandom_range(1, 15));
            dump_req = r;
            do_dump(0, 0, bit'($urandom_range(0, 1)), c0);
            dump_req = 4'b0;
            n = $urandom_range(1, 3);
            for (int g = 0; g < n; g++) begin
                tick();
                chk("gap_ack", dump_ack, 0);
            end
        end
        chk("bad_writes", bad_wr, 0);

        // Small build: 2 channels, one accumulator word.
        en2 = 1'b1;
        req2 = 2'b10;
        n = 0;
        while (ack2 === 2'b0 && n < 20) begin
            tick();
            n++;
        end
        chk("c1_grant", ack2, 2'b10);
        chk("c1_first", addr2, 6);
        req2 = 2'b0;
        n = 0;
        last = 0;
        while (done2 !== 1'b1 && n < 40) begin
            last = addr2;
            tick();
            n++;
        end
        chk("c1_latency", n, 10);
        chk("c1_last", last, 16);
        chk("c1_baddr", baddr2, 6'h30);
        chk("c1_dch", done_ch2, 1);
        chk("c1_wdata", wdata2, mem[1][16]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
